// File: rtl/snake_motion_engine.sv
// snake_motion_engine: game-logic stage upstream of the grid register.
// Keeps the snake body in a coordinate ring buffer. On each accepted move tick
// it probes the cell ahead of the head, writes the new head, erases the tail
// unless growing, and raises a sticky game_over on collision.
// Optional feature macro: SNAKE_SNACK_RESPAWN_EN. When defined, each eaten
// snack is respawned at a free in-arena cell chosen by a free-running LFSR.
module snake_motion_engine #(
    parameter int MAX_LEN     = 64,
    parameter int INIT_LEN    = 3,
    parameter int START_X     = 8,
    parameter int START_Y     = 12,
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        move_tick,
    input  logic [1:0]  dir,
    input  logic [3:0]  rect_read_out,
    output logic [31:0] rect_read_in,
    output logic [35:0] rect_write,
    output logic        game_over,
    output logic        busy,
    output logic [6:0]  length,
    output logic [15:0] score
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [3:0] CELL_NULL  = 4'd0;
    localparam logic [3:0] CELL_SNAKE = 4'd1;
    localparam logic [3:0] CELL_ROCK  = 4'd2;
    localparam logic [3:0] CELL_SNACK = 4'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_SEED,
        S_RUN,
        S_PROBE,
        S_WRITE_HEAD,
        S_ERASE,
        S_DEAD
`ifdef SNAKE_SNACK_RESPAWN_EN
        , S_SPAWN,
        S_SPAWN_PROBE,
        S_SPAWN_WRITE
`endif
    } state_t;

    state_t state, next_state;

    // x needs 6 bits internally so the right border column 32 does not wrap to 0
    logic [1:0]       cur_dir, pend_dir, acc_dir;
    logic             dir_rev, push, grow, busy_nxt;
    logic [5:0]       head_x, hx, nhx, tail_x, seed_x, wr_x, wr_x_nxt, rd_x, rd_x_nxt;
    logic [4:0]       head_y, hy, nhy, tail_y, wr_y, wr_y_nxt, rd_y, rd_y_nxt;
    logic [3:0]       wr_fn, wr_fn_nxt;
    logic [15:0]      cnt;
    logic [PTR_W-1:0] head_ptr, tail_ptr;
    logic [10:0]      ring [MAX_LEN];

    assign rect_read_in = {10'd0, rd_x, 11'd0, rd_y};
    assign rect_write   = {10'd0, wr_x, 11'd0, wr_y, wr_fn};

    assign dir_rev = (pend_dir[1] == cur_dir[1]) && (pend_dir[0] != cur_dir[0]);
    assign acc_dir = dir_rev ? cur_dir : pend_dir;
    assign push    = (state == S_SEED) || (state == S_WRITE_HEAD);
    assign {tail_x, tail_y} = ring[tail_ptr];
    assign seed_x  = 6'(START_X - INIT_LEN + 1) + ((state == S_SEED) ? 6'(cnt + 16'd1) : 6'd0);

`ifdef SNAKE_SNACK_RESPAWN_EN
    logic [15:0] lfsr;
    logic [5:0]  sx;
    logic [4:0]  sy;
    logic        snack, cand_ok;

    // a 5-bit x candidate can never exceed 31, so only the lower bound needs checking
    assign cand_ok = (lfsr[4:0] >= 5'd2) && (lfsr[9:5] >= 5'd1) && (lfsr[9:5] <= 5'd22);

    // Free-running LFSR, latched spawn candidate and the snack-eaten flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr  <= 16'hACE1;
            sx    <= 6'd0;
            sy    <= 5'd0;
            snack <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (state == S_SPAWN && cand_ok) begin
                sx <= {1'b0, lfsr[4:0]};
                sy <= lfsr[9:5];
            end
            if (state == S_PROBE)
                snack <= (rect_read_out == CELL_SNACK);
        end
    end
`endif

    // Next head position one step from the current head along the accepted direction
    always_comb begin
        nhx = head_x;
        nhy = head_y;
        case (acc_dir)
            2'b00:   nhy = head_y - 5'd1;
            2'b01:   nhy = head_y + 5'd1;
            2'b10:   nhx = head_x - 6'd1;
            default: nhx = head_x + 6'd1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decision
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (game_start) next_state = S_WAIT;
            S_WAIT:       if (cnt == 16'(START_DELAY - 1)) next_state = S_SEED;
            S_SEED:       if (cnt == 16'(INIT_LEN - 1)) next_state = S_RUN;
            S_RUN:        if (move_tick) next_state = S_PROBE;
            S_PROBE:      next_state = (rect_read_out == CELL_SNAKE || rect_read_out == CELL_ROCK)
                                       ? S_DEAD : S_WRITE_HEAD;
`ifdef SNAKE_SNACK_RESPAWN_EN
            S_WRITE_HEAD: next_state = grow ? S_SPAWN : S_ERASE;
            S_ERASE:      next_state = snack ? S_SPAWN : S_RUN;
            S_SPAWN:      if (cand_ok) next_state = S_SPAWN_PROBE;
            S_SPAWN_PROBE: next_state = (rect_read_out == CELL_NULL) ? S_SPAWN_WRITE : S_SPAWN;
            S_SPAWN_WRITE: next_state = S_RUN;
`else
            S_WRITE_HEAD: next_state = grow ? S_RUN : S_ERASE;
            S_ERASE:      next_state = S_RUN;
`endif
            S_DEAD:       next_state = S_DEAD;
            default:      next_state = S_IDLE;
        endcase
    end

    // Port values for the coming cycle, derived from the state being entered
    always_comb begin
        wr_x_nxt  = 6'd0;
        wr_y_nxt  = 5'd0;
        wr_fn_nxt = CELL_NULL;
        rd_x_nxt  = 6'd0;
        rd_y_nxt  = 5'd0;
        busy_nxt  = 1'b1;
        case (next_state)
            S_IDLE, S_RUN, S_DEAD: busy_nxt = 1'b0;
            S_SEED: begin
                wr_x_nxt  = seed_x;
                wr_y_nxt  = 5'(START_Y);
                wr_fn_nxt = CELL_SNAKE;
            end
            S_PROBE: begin
                rd_x_nxt = nhx;
                rd_y_nxt = nhy;
            end
            S_WRITE_HEAD: begin
                wr_x_nxt  = hx;
                wr_y_nxt  = hy;
                wr_fn_nxt = CELL_SNAKE;
            end
            S_ERASE: begin
                wr_x_nxt = tail_x;
                wr_y_nxt = tail_y;
            end
`ifdef SNAKE_SNACK_RESPAWN_EN
            S_SPAWN_PROBE: begin
                rd_x_nxt = {1'b0, lfsr[4:0]};
                rd_y_nxt = lfsr[9:5];
            end
            S_SPAWN_WRITE: begin
                wr_x_nxt  = sx;
                wr_y_nxt  = sy;
                wr_fn_nxt = CELL_SNACK;
            end
`endif
            default: ;
        endcase
    end

    // Body ring storage; stale entries are harmless because only the pointers define the body
    always_ff @(posedge clk) begin
        if (push) ring[head_ptr] <= {wr_x, wr_y};
    end

    // Registered ports, direction tracking, pointers and game counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_x      <= 6'd0;
            wr_y      <= 5'd0;
            wr_fn     <= CELL_NULL;
            rd_x      <= 6'd0;
            rd_y      <= 5'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            length    <= 7'd0;
            score     <= 16'd0;
            cur_dir   <= 2'b11;
            pend_dir  <= 2'b11;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            head_x    <= 6'd0;
            head_y    <= 5'd0;
            hx        <= 6'd0;
            hy        <= 5'd0;
            grow      <= 1'b0;
            cnt       <= 16'd0;
        end else begin
            wr_x     <= wr_x_nxt;
            wr_y     <= wr_y_nxt;
            wr_fn    <= wr_fn_nxt;
            rd_x     <= rd_x_nxt;
            rd_y     <= rd_y_nxt;
            busy     <= busy_nxt;
            pend_dir <= dir;
            if (next_state != state)
                cnt <= 16'd0;
            else if (state == S_WAIT || state == S_SEED)
                cnt <= cnt + 16'd1;
            if (state == S_RUN && move_tick) begin
                cur_dir <= acc_dir;
                hx      <= nhx;
                hy      <= nhy;
            end
            if (state == S_SEED && next_state == S_RUN) begin
                cur_dir <= 2'b11;
                length  <= 7'(INIT_LEN);
            end
            if (push) begin
                head_ptr <= head_ptr + PTR_W'(1);
                head_x   <= wr_x;
                head_y   <= wr_y;
            end
            if (state == S_PROBE) begin
                grow <= (rect_read_out == CELL_SNACK) && (length < 7'(MAX_LEN));
                if (rect_read_out == CELL_SNACK)
                    score <= score + 16'd1;
            end
            if (state == S_WRITE_HEAD && grow)
                length <= length + 7'd1;
            if (state == S_ERASE)
                tail_ptr <= tail_ptr + PTR_W'(1);
            if (next_state == S_DEAD)
                game_over <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snake_motion_engine.sv
// tb_snake_motion_engine: scoreboard bench for snake_motion_engine.
// Expected probes/writes are queued with their cycle when a move is driven and
// matched by a monitor as the engine produces them.
module tb_snake_motion_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_start;
    logic        move_tick;
    logic [1:0]  dir;
    logic [3:0]  rect_read_out;
    logic [31:0] rect_read_in;
    logic [35:0] rect_write;
    logic        game_over;
    logic        busy;
    logic [6:0]  length;
    logic [15:0] score;

    typedef struct {
        logic [35:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_wr[$];
    exp_t        exp_rd[$];
    int          check_count = 0;
    int          fail_count  = 0;
    int          cyc = 0;
    logic [31:0] target_addr = 32'hFFFF_FFFF;
    logic [3:0]  target_code = 4'd0;

    int          body_x[$];
    int          body_y[$];
    logic [1:0]  model_dir;
    int          model_len;
    int          model_score;
    bit          model_dead;

    snake_motion_engine dut (
        .clk           (clk),
        .rst           (rst),
        .game_start    (game_start),
        .move_tick     (move_tick),
        .dir           (dir),
        .rect_read_out (rect_read_out),
        .rect_read_in  (rect_read_in),
        .rect_write    (rect_write),
        .game_over     (game_over),
        .busy          (busy),
        .length        (length),
        .score         (score)
    );

    // Grid stand-in: only the targeted cell returns a non-NULL code
    assign rect_read_out = (rect_read_in == target_addr) ? target_code : 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] pack(input int x, input int y);
        return {x[15:0], y[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic pushRead(input int x, input int y, input int c);
        exp_t e;
        e.val = {4'd0, pack(x, y)};
        e.cyc = c;
        exp_rd.push_back(e);
    endtask

    task automatic pushWrite(input int x, input int y, input logic [3:0] fn, input int c);
        exp_t e;
        e.val = {pack(x, y), fn};
        e.cyc = c;
        exp_wr.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 0);
    endtask

    // Monitor: every non-parked port value must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rect_read_in != 32'd0) begin
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    checkOutput("probe_addr", rect_read_in, e.val);
                    checkOutput("probe_cycle", cyc, e.cyc);
                end else begin
`ifndef SNAKE_SNACK_RESPAWN_EN
                    checkOutput("unexpected_probe", rect_read_in, 0);
`endif
                end
            end
            if (rect_write != 36'd0) begin
`ifdef SNAKE_SNACK_RESPAWN_EN
                if (rect_write[3:0] == 4'd4) begin
                    checkOutput("spawn_in_range",
                        (rect_write[35:20] >= 2 && rect_write[35:20] <= 31 &&
                         rect_write[19:4] >= 1 && rect_write[19:4] <= 22), 1);
                end else
`endif
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    checkOutput("write_value", rect_write, e.val);
                    checkOutput("write_cycle", cyc, e.cyc);
                end else begin
                    checkOutput("unexpected_write", rect_write, 0);
                end
            end
        end
    end

    // Start a game from IDLE and queue the seeded body writes
    task automatic startGame();
        int t;
        @(negedge clk);
        game_start = 1'b1;
        t = cyc;
        for (int k = 0; k < 3; k++) pushWrite(6 + k, 12, 4'd1, t + 5 + k);
        body_x = {6, 7, 8};
        body_y = {12, 12, 12};
        model_dir   = 2'b11;
        model_len   = 3;
        model_score = 0;
        model_dead  = 0;
        @(negedge clk);
        game_start = 1'b0;
        checkOutput("wait_busy", busy, 1);
        while (cyc < t + 8) @(negedge clk);
        checkOutput("seed_length", length, 3);
        checkOutput("seed_busy", busy, 0);
    endtask

    // One move: present direction, pulse a tick, and queue the expected grid traffic
    task automatic applyStimulus(input logic [1:0] d, input logic [3:0] code);
        int  nx, ny, t;
        bit  died;
        died = 0;
        @(negedge clk);
        dir = d;
        @(negedge clk);
        t = cyc;
        if (!model_dead) begin
            if (!(d[1] == model_dir[1] && d[0] != model_dir[0])) model_dir = d;
            nx = body_x[$];
            ny = body_y[$];
            case (model_dir)
                2'b00:   ny--;
                2'b01:   ny++;
                2'b10:   nx--;
                default: nx++;
            endcase
            target_addr = pack(nx, ny);
            target_code = code;
            pushRead(nx, ny, t + 1);
            if (code == 4'd1 || code == 4'd2) begin
                model_dead = 1;
                died = 1;
            end else begin
                pushWrite(nx, ny, 4'd1, t + 2);
                body_x.push_back(nx);
                body_y.push_back(ny);
                if (code == 4'd4) model_score++;
                if (code == 4'd4 && model_len < 64) begin
                    model_len++;
                end else begin
                    pushWrite(body_x[0], body_y[0], 4'd0, t + 3);
                    void'(body_x.pop_front());
                    void'(body_y.pop_front());
                end
            end
        end
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        if (died) begin
            checkOutput("game_over_during_probe", game_over, 0);
            @(negedge clk);
            checkOutput("game_over_after_probe", game_over, 1);
        end
        repeat (3) @(negedge clk);
        waitIdle();
        checkOutput("length", length, model_len);
        checkOutput("score", score, model_score);
        checkOutput("game_over", game_over, model_dead);
    endtask

    initial begin
        int t;
        rst        = 1'b1;
        game_start = 1'b0;
        move_tick  = 1'b0;
        dir        = 2'b11;
        repeat (3) @(negedge clk);
        checkOutput("reset_game_over", game_over, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_length", length, 0);
        checkOutput("reset_score", score, 0);
        checkOutput("reset_write_park", rect_write, 0);
        checkOutput("reset_read_park", rect_read_in, 0);
        rst = 1'b0;

        startGame();
        applyStimulus(2'b11, 4'd0);
        applyStimulus(2'b10, 4'd0);
        applyStimulus(2'b01, 4'd0);
        applyStimulus(2'b10, 4'd4);
        applyStimulus(2'b11, 4'd0);
        applyStimulus(2'b00, 4'd2);
        applyStimulus(2'b01, 4'd0);

        @(negedge clk);
        game_start = 1'b1;
        repeat (8) @(negedge clk);
        game_start = 1'b0;
        checkOutput("dead_game_over", game_over, 1);
        checkOutput("dead_busy", busy, 0);
        checkOutput("dead_length", length, 4);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        startGame();
        @(negedge clk);
        dir = 2'b11;
        @(negedge clk);
        t = cyc;
        target_addr = 32'hFFFF_FFFF;
        pushRead(9, 12, t + 1);
        pushWrite(9, 12, 4'd1, t + 2);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_write_park", rect_write, 0);
        checkOutput("abort_read_park", rect_read_in, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_length", length, 0);
        checkOutput("abort_score", score, 0);
        checkOutput("abort_game_over", game_over, 0);
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_abort_write_park", rect_write, 0);
        checkOutput("post_abort_busy", busy, 0);

        checkOutput("read_queue_drained", exp_rd.size(), 0);
        checkOutput("write_queue_drained", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
